// File: rtl/cpa_if.sv
// Operand/result bundle for cpa_pipe. The sub_in signal exists only when CPA_SUB_EN is defined.
interface cpa_if #(parameter int WIDTH = 32) ();
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
`ifdef CPA_SUB_EN
  logic             sub_in;
`endif
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH:0]   sum;
  logic             valid_out;
  logic             ready_in;

`ifdef CPA_SUB_EN
  modport master (output x_in, y_in, sub_in, valid_in, ready_in,
                  input  ready_out, sum, valid_out);
  modport slave  (input  x_in, y_in, sub_in, valid_in, ready_in,
                  output ready_out, sum, valid_out);
`else
  modport master (output x_in, y_in, valid_in, ready_in,
                  input  ready_out, sum, valid_out);
  modport slave  (input  x_in, y_in, valid_in, ready_in,
                  output ready_out, sum, valid_out);
`endif
endinterface

// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder: one SEG-bit carry segment resolved per register stage.
// Optional subtract mode is enabled by defining CPA_SUB_EN.
module cpa_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic  clk,
  input logic  rst_n,
  cpa_if.slave bus
);
  localparam int NST = (WIDTH + SEG - 1) / SEG;

  // Handshake: an operand pair transfers on a rising edge where valid_in & ready_out;
  // a result transfers where valid_out & ready_in. The whole pipe advances together
  // when the output slot is empty or being drained, so ready_out = ready_in | ~valid_out.
  logic             adv;
  logic             accept;
  logic             c0;
  logic [WIDTH-1:0] x_eff;
  logic [WIDTH-1:0] y_eff;

  assign adv           = bus.ready_in | ~bus.valid_out;
  assign bus.ready_out = adv;
  assign accept        = bus.valid_in & adv;
  assign x_eff         = bus.x_in;

`ifdef CPA_SUB_EN
  // Two's-complement subtract: invert Y for the whole word and inject the +1 at stage 0.
  assign y_eff = bus.sub_in ? ~bus.y_in : bus.y_in;
  assign c0    = bus.sub_in;
`else
  assign y_eff = bus.y_in;
  assign c0    = 1'b0;
`endif

  for (genvar k = 0; k < NST; k++) begin : stg
    localparam int LO  = k * SEG;
    localparam int HI  = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;
    localparam int W   = HI - LO + 1;
    localparam int REM = WIDTH - 1 - HI;

    logic [W-1:0] ax;
    logic [W-1:0] ay;
    logic         ci;
    logic [W:0]   t;
    logic         v;
    logic         c;
    logic [HI:0]  s;

    assign t = {1'b0, ax} + {1'b0, ay} + {{W{1'b0}}, ci};

    if (k == 0) begin : g_in
      assign ax = x_eff[HI:0];
      assign ay = y_eff[HI:0];
      assign ci = c0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= 1'b0;
          c <= 1'b0;
          s <= '0;
        end else if (adv) begin
          v <= accept;
          c <= t[W];
          s <= t[W-1:0];
        end
      end
    end else begin : g_in
      // Low W bits of the skewed operands from the previous stage are this segment.
      assign ax = stg[k-1].g_fwd.xr[W-1:0];
      assign ay = stg[k-1].g_fwd.yr[W-1:0];
      assign ci = stg[k-1].c;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= 1'b0;
          c <= 1'b0;
          s <= '0;
        end else if (adv) begin
          v <= stg[k-1].v;
          c <= t[W];
          s <= {t[W-1:0], stg[k-1].s};
        end
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] xr;
      logic [REM-1:0] yr;

      if (k == 0) begin : g_src
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            xr <= '0;
            yr <= '0;
          end else if (adv) begin
            xr <= x_eff[WIDTH-1:HI+1];
            yr <= y_eff[WIDTH-1:HI+1];
          end
        end
      end else begin : g_src
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            xr <= '0;
            yr <= '0;
          end else if (adv) begin
            xr <= stg[k-1].g_fwd.xr[REM+W-1:W];
            yr <= stg[k-1].g_fwd.yr[REM+W-1:W];
          end
        end
      end
    end
  end

  assign bus.sum       = {stg[NST-1].c, stg[NST-1].s};
  assign bus.valid_out = stg[NST-1].v;

endmodule
